// File: rtl/fibo_seq_engine.sv
// Fibonacci-type sequence generator with a valid/ready term stream and per-term overflow flag.
// Control FSM and a/b register datapath live together in this single block.
module fibo_seq_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH-1:0] term,
    output logic [CNT_W-1:0] term_idx,
    output logic             term_ovf,
    output logic             term_valid,
    input  logic             term_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a, a_d;
    logic [WIDTH-1:0] b, b_d;
    logic             a_ovf, a_ovf_d;
    logic             b_ovf, b_ovf_d;
    logic [CNT_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] n, n_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum;
    logic             handshake;
    logic             last_term;

    // The extra MSB of the sum is the carry that marks a wrapped next term.
    assign sum       = {1'b0, a} + {1'b0, b};
    assign handshake = (state == S_EMIT) && term_ready;
    assign last_term = (idx == n - CNT_W'(1));

    // NOTE: every variable gets its hold/default value first, so no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        a_ovf_d = a_ovf;
        b_ovf_d = b_ovf;
        idx_d   = idx;
        n_d     = n;
        ovf_d   = ovf_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_terms;
                    a_d     = mode ? seed_a : '0;
                    b_d     = mode ? seed_b : WIDTH'(1);
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (n_terms != '0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    if (a_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (last_term) begin
                        state_d = S_DONE;
                    end else begin
                        a_d     = b;
                        a_ovf_d = b_ovf;
                        b_d     = sum[WIDTH-1:0];
                        b_ovf_d = sum[WIDTH] | a_ovf | b_ovf;
                        idx_d   = idx + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            a     <= '0;
            b     <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            idx   <= '0;
            n     <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_d;
            a     <= a_d;
            b     <= b_d;
            a_ovf <= a_ovf_d;
            b_ovf <= b_ovf_d;
            idx   <= idx_d;
            n     <= n_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs are decoded from registered state only; outside EMIT the term bus reads as zero.
    assign term_valid = (state == S_EMIT);
    assign busy       = (state == S_EMIT);
    assign done       = (state == S_DONE);
    assign term       = term_valid ? a : '0;
    assign term_idx   = term_valid ? idx : '0;
    assign term_ovf   = term_valid ? a_ovf : 1'b0;
    assign overflow   = ovf_q;

`ifndef SYNTHESIS
    // A stalled term must not change under the consumer.
    assert property (@(posedge clk) disable iff (reset)
        (term_valid && !term_ready) |=> (term_valid && $stable(term) && $stable(term_idx)));
    assert property (@(posedge clk) disable iff (reset) !(done && busy));
`endif

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Directed bench for fibo_seq_engine: a 16-bit instance for stream/handshake behaviour
// and an 8-bit instance for wrap and overflow behaviour.
module tb_fibo_seq_engine;

    logic clk = 1'b0;
    logic reset;

    // 16-bit instance
    logic        start, mode, term_ready;
    logic [7:0]  n_terms;
    logic [15:0] seed_a, seed_b;
    logic [15:0] term;
    logic [7:0]  term_idx;
    logic        term_ovf, term_valid, busy, done, overflow;

    // 8-bit instance
    logic        start8, mode8, ready8;
    logic [7:0]  n8, sa8, sb8;
    logic [7:0]  term8, idx8;
    logic        ovf8, valid8, busy8, done8, overflow8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fibo_seq_engine #(.WIDTH(16), .CNT_W(8)) u16 (
        .clk(clk), .reset(reset), .start(start), .n_terms(n_terms), .mode(mode),
        .seed_a(seed_a), .seed_b(seed_b), .term(term), .term_idx(term_idx),
        .term_ovf(term_ovf), .term_valid(term_valid), .term_ready(term_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    fibo_seq_engine #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .n_terms(n8), .mode(mode8),
        .seed_a(sa8), .seed_b(sb8), .term(term8), .term_idx(idx8),
        .term_ovf(ovf8), .term_valid(valid8), .term_ready(ready8),
        .busy(busy8), .done(done8), .overflow(overflow8)
    );

    typedef struct {
        logic        ready;
        logic        valid;
        logic        done;
        logic [15:0] term;
        logic [7:0]  idx;
    } row_t;

    row_t tbl[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic row_t mk(input logic r, input logic v, input logic d,
                                input logic [15:0] t, input logic [7:0] x);
        row_t rw;
        rw.ready = r; rw.valid = v; rw.done = d; rw.term = t; rw.idx = x;
        return rw;
    endfunction

    // {valid, busy, done, term_ovf, idx, term} of the 16-bit instance
    function automatic logic [63:0] obs16();
        return {36'd0, term_valid, busy, done, term_ovf, term_idx, term};
    endfunction

    task automatic start_run16(input logic m, input logic [15:0] sa, input logic [15:0] sb,
                               input logic [7:0] cnt);
        @(negedge clk);
        start = 1'b1; mode = m; seed_a = sa; seed_b = sb; n_terms = cnt;
        @(posedge clk);
        #1 start = 1'b0;
        mode = 1'b0; seed_a = 16'hdead; seed_b = 16'hbeef; n_terms = 8'hff;
    endtask

    task automatic apply_rows(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            term_ready = tbl[i].ready;
            check($sformatf("%s row %0d", tag, i), obs16(),
                  {36'd0, tbl[i].valid, tbl[i].valid, tbl[i].done, 1'b0, tbl[i].idx, tbl[i].term});
        end
    endtask

    logic [15:0] fib[10]   = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34};
    logic [15:0] lucas[6]  = '{16'd2, 16'd1, 16'd3, 16'd4, 16'd7, 16'd11};
    logic [7:0]  fib8[16]  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

    initial begin
        reset = 1'b1;
        start = 1'b0; mode = 1'b0; term_ready = 1'b1; n_terms = '0; seed_a = '0; seed_b = '0;
        start8 = 1'b0; mode8 = 1'b0; ready8 = 1'b1; n8 = '0; sa8 = '0; sb8 = '0;

        // Reset state
        #12;
        check("reset outputs16", obs16(), 64'd0);
        check("reset overflow16", {63'd0, overflow}, 64'd0);
        check("reset outputs8", {46'd0, valid8, busy8, done8, ovf8, idx8, term8, overflow8}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fibonacci run, ready held high: one term per cycle, done right after 34
        for (int i = 0; i < 10; i++) tbl[i] = mk(1'b1, 1'b1, 1'b0, fib[i], 8'(i));
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 16'd0, 8'd0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        start_run16(1'b0, 16'd0, 16'd0, 8'd10);
        apply_rows("fib", 12);
        check("fib overflow", {63'd0, overflow}, 64'd0);

        // Same run under backpressure: stalled terms hold, none lost or duplicated
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 16'd0,  8'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 16'd0,  8'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'd1,  8'd1);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 16'd1,  8'd2);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 16'd1,  8'd2);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 16'd1,  8'd2);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 16'd2,  8'd3);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 16'd3,  8'd4);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 16'd3,  8'd4);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 16'd5,  8'd5);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 16'd8,  8'd6);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 16'd8,  8'd6);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 16'd13, 8'd7);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 16'd21, 8'd8);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 16'd34, 8'd9);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 16'd34, 8'd9);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 16'd34, 8'd9);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 16'd0,  8'd0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 16'd0,  8'd0);
        start_run16(1'b0, 16'd0, 16'd0, 8'd10);
        apply_rows("bp", 19);

        // Custom seeds (Lucas) with a stray start mid-run and during the done cycle
        term_ready = 1'b1;
        start_run16(1'b1, 16'd2, 16'd1, 8'd6);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("lucas %0d", k), obs16(),
                  {36'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(k), lucas[k]});
            start = (k == 2);
        end
        @(negedge clk);
        check("lucas done", {61'd0, term_valid, busy, done}, 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lucas idle after done", {61'd0, term_valid, busy, done}, 64'd0);
        @(negedge clk);
        check("start in done ignored", {61'd0, term_valid, busy, done}, 64'd0);

        // Zero count: done one cycle after the start edge, no term_valid
        start_run16(1'b0, 16'd0, 16'd0, 8'd0);
        @(negedge clk);
        check("zero done", {61'd0, term_valid, busy, done}, 64'd1);
        @(negedge clk);
        check("zero idle", {61'd0, term_valid, busy, done}, 64'd0);

        // 8-bit wrap and sticky overflow
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; n8 = 8'd16; ready8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0; n8 = 8'd0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("wrap term %0d", k), {46'd0, valid8, ovf8, idx8, term8},
                  {46'd0, 1'b1, (k >= 14) ? 1'b1 : 1'b0, 8'(k), fib8[k]});
            check($sformatf("wrap sticky %0d", k), {63'd0, overflow8}, {63'd0, (k == 15) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
        check("wrap done", {62'd0, done8, overflow8}, 64'd3);
        @(negedge clk);
        check("wrap idle holds overflow", {61'd0, valid8, done8, overflow8}, 64'd1);
        start8 = 1'b1; n8 = 8'd1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        check("overflow cleared by start", {53'd0, overflow8, valid8, idx8, term8}, {53'd0, 1'b0, 1'b1, 16'd0});
        @(negedge clk);
        check("single-term done", {62'd0, done8, overflow8}, 64'd2);

        // Asynchronous reset mid-run, then a fresh 3-term run
        term_ready = 1'b1;
        start_run16(1'b0, 16'd0, 16'd0, 8'd10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("pre-reset %0d", k), {40'd0, term_idx, term}, {40'd0, 8'(k), fib[k]});
        end
        reset = 1'b1;
        #1;
        check("reset mid-run", {36'd0, overflow, term_valid, busy, done, term_ovf, term_idx, term}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", obs16(), 64'd0);
        for (int i = 0; i < 3; i++) tbl[i] = mk(1'b1, 1'b1, 1'b0, fib[i], 8'(i));
        tbl[3] = mk(1'b1, 1'b0, 1'b1, 16'd0, 8'd0);
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        start_run16(1'b0, 16'd0, 16'd0, 8'd3);
        apply_rows("post-reset", 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fibo_seq_engine.md
# fibo_seq_engine

Parametrised Fibonacci-type sequence generator that merges the existing control FSM and its register-file/ALU datapath into one self-contained block. It is generalised in data width, term count and seed values. It streams terms over a valid/ready handshake, so downstream logic can apply backpressure. It flags arithmetic overflow per term. It sits between the front-panel/host control logic (start, n_terms, seeds) and any display or storage consumer of the series.

## Interface
- WIDTH, 16, term and seed width in bits (≥2)
- CNT_W, 8, width of term count and term index
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a run; sampled only in IDLE
- n_terms  input  CNT_W  number of terms to emit (0 allowed); latched on accepted start
- mode  input  1  0 = Fibonacci seeds (0,1); 1 = custom seeds from seed_a/seed_b; latched on accepted start
- seed_a  input  WIDTH  first term when mode=1
- seed_b  input  WIDTH  second term when mode=1
- term  output  WIDTH  current term value (wrapped modulo 2^WIDTH)
- term_idx  output  CNT_W  zero-based index of the current term
- term_ovf  output  1  current term's true value exceeds 2^WIDTH−1
- term_valid  output  1  term, term_idx and term_ovf are valid
- term_ready  input  1  consumer accepts the term
- busy  output  1  run in progress (EMIT state)
- done  output  1  one-cycle pulse when a run ends
- overflow  output  1  sticky: at least one emitted term in this run had term_ovf=1

## Operation
- Internal registers:
  - a holds the current term; b holds the next term.
  - a_ovf and b_ovf are the matching wrap flags.
  - idx counts terms; n holds the latched count; overflow is the sticky flag.
- States and transitions:
  - IDLE: all outputs low. On start=1, latch n := n_terms.
    - Load a:=0, b:=1 (mode=0) or a:=seed_a, b:=seed_b (mode=1).
    - Clear idx, a_ovf, b_ovf and overflow.
    - Go to EMIT if n_terms≠0, else go to DONE.
  - EMIT: term_valid=1, busy=1, term=a, term_idx=idx, term_ovf=a_ovf. Outputs hold stable while term_ready=0.
    - A handshake occurs when term_valid and term_ready are both 1 at the clock edge.
    - On handshake, if a_ovf=1, overflow is set.
    - On handshake, if idx = n−1, go to DONE.
    - Otherwise: a:=b, a_ovf:=b_ovf, b:=(a+b) mod 2^WIDTH, b_ovf:=carry_out|a_ovf|b_ovf, idx:=idx+1, stay in EMIT.
  - DONE: done=1 for exactly one cycle, term_valid=0, busy=0, then return to IDLE. overflow holds its value.
- start is ignored in EMIT and DONE.
- n_terms, mode and seeds are don't-care outside the start-accept cycle.
- overflow holds through IDLE until the next accepted start or reset.
- With n_terms = 2^CNT_W−1, idx reaches its maximum without wrapping.

## Timing
- Reset (asynchronous, immediate) returns the block to IDLE. term, term_idx, term_ovf, term_valid, busy, done and overflow all go to 0, including mid-run. The partially emitted run is abandoned.
- Start accepted at edge T: term_valid=1 with idx 0 from T+1.
- With term_ready held at 1, the block emits one term per cycle. Term k appears at T+1+k.
- The last handshake at edge L: done=1 during L+1, IDLE from L+2. A start in the L+1 cycle is ignored; a start is accepted at the L+2 edge at the earliest.
- n_terms=0: done=1 during T+1 and term_valid never rises.
- busy and term_valid are identical; done and busy are never high together.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs. The next-state and next-value logic does depend combinationally on term_ready.

## Test plan
- Fibonacci run: WIDTH=16, mode=0, n_terms=10, term_ready=1 → terms 0,1,1,2,3,5,8,13,21,34 with idx 0..9 on consecutive cycles. done pulses one cycle after 34; overflow=0.
- Backpressure: the same run with term_ready toggled pseudo-randomly → identical sequence. term, term_idx and term_valid stay stable while ready=0, and there are no lost or duplicated terms.
- Overflow: WIDTH=8, mode=0, n_terms=16 → idx 13 = 233 (term_ovf=0), idx 14 = 121 (377 wrapped), idx 15 = 98 (610 wrapped). term_ovf=1 on idx 14 and 15; overflow=1 after the idx-14 handshake and held in IDLE. overflow is cleared by the next start.
- Custom seeds: mode=1, seed_a=2, seed_b=1, n_terms=6 → Lucas terms 2,1,3,4,7,11. A second start pulse issued mid-run is ignored.
- Zero count: n_terms=0 → no term_valid; done=1 exactly one cycle after the start edge, then IDLE.
- Reset mid-run: reset asserted between clock edges at idx 4 of a 10-term run → all outputs are 0 immediately. After release the block is in IDLE; a new start (n_terms=3) yields 0,1,1 and done.
